// File: rtl/csel_pkg.sv
// Shared mode constants, default geometry and the stage control record
// for the pipelined carry-select adder/subtractor.
package csel_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_BLOCK = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Control fields carried with each stage-1 entry; the wide candidate
  // vectors travel alongside it as separate registers.
  typedef struct packed {
    logic  valid;
    mode_e mode;
    logic  cin;
    logic  a_msb;
    logic  bx_msb;
  } stage_ctl_t;

  // Subtraction is a + ~b + !borrow_in, so the block-0 carry flips in sub mode.
  function automatic logic carry_in_eff(input mode_e mode, input logic c_in);
    return (mode == MODE_SUB) ? ~c_in : c_in;
  endfunction

endpackage

// File: rtl/csel_block.sv
// One BLOCK-bit carry-select slice: both candidate sums and carries,
// for a block carry-in of 0 and of 1.
module csel_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic [BLOCK-1:0] sum1,
  output logic             cout0,
  output logic             cout1
);

  assign {cout0, sum0} = {1'b0, a} + {1'b0, b};
  assign {cout1, sum1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

endmodule

// File: rtl/pipelined_csel_addsub.sv
// Two-stage valid/ready carry-select adder/subtractor with c_out, ovf and zero flags.
// Optional saturation on signed overflow via the CSEL_ADDSUB_SAT_EN macro (adds port sat).
module pipelined_csel_addsub
  import csel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
`ifdef CSEL_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NB = WIDTH / BLOCK;

  if (((WIDTH % BLOCK) != 0) || (WIDTH < 4)) begin : g_param_err
    $error("pipelined_csel_addsub: WIDTH must be a multiple of BLOCK and at least 4");
  end

  mode_e            in_mode;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] blk_sum0;
  logic [WIDTH-1:0] blk_sum1;
  logic [NB-1:0]    blk_cout0;
  logic [NB-1:0]    blk_cout1;

  stage_ctl_t       s1_ctl;
  logic [WIDTH-1:0] s1_sum0;
  logic [WIDTH-1:0] s1_sum1;
  logic [NB-1:0]    s1_cout0;
  logic [NB-1:0]    s1_cout1;

  logic             s2_take;
  logic [NB:0]      chain;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] res_sum;
  logic             res_ovf;

  assign in_mode = mode_e'(sub);
  assign b_x     = (in_mode == MODE_SUB) ? ~b : b;

  // Stage 2 can take a new entry when empty or when its result drains this cycle.
  assign s2_take  = !out_valid || out_ready;
  assign in_ready = !s1_ctl.valid || s2_take;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    csel_block #(.BLOCK(BLOCK)) u_blk (
      .a     (a[i*BLOCK +: BLOCK]),
      .b     (b_x[i*BLOCK +: BLOCK]),
      .sum0  (blk_sum0[i*BLOCK +: BLOCK]),
      .sum1  (blk_sum1[i*BLOCK +: BLOCK]),
      .cout0 (blk_cout0[i]),
      .cout1 (blk_cout1[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctl   <= '0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_cout0 <= '0;
      s1_cout1 <= '0;
    end else if (in_ready) begin
      s1_ctl.valid <= in_valid;
      if (in_valid) begin
        s1_ctl.mode   <= in_mode;
        s1_ctl.cin    <= carry_in_eff(in_mode, c_in);
        s1_ctl.a_msb  <= a[WIDTH-1];
        s1_ctl.bx_msb <= b_x[WIDTH-1];
        s1_sum0       <= blk_sum0;
        s1_sum1       <= blk_sum1;
        s1_cout0      <= blk_cout0;
        s1_cout1      <= blk_cout1;
      end
    end
  end

`ifdef CSEL_ADDSUB_SAT_EN
  logic s1_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sat <= 1'b0;
    end else if (in_ready && in_valid) begin
      s1_sat <= sat;
    end
  end
`endif

  // Ripple only the block-select muxes; each block already has both answers.
  always_comb begin
    chain    = '0;
    raw_sum  = '0;
    chain[0] = s1_ctl.cin;
    for (int i = 0; i < NB; i++) begin
      raw_sum[i*BLOCK +: BLOCK] = chain[i] ? s1_sum1[i*BLOCK +: BLOCK]
                                           : s1_sum0[i*BLOCK +: BLOCK];
      chain[i+1] = chain[i] ? s1_cout1[i] : s1_cout0[i];
    end
  end

  assign res_ovf = (s1_ctl.a_msb == s1_ctl.bx_msb) && (raw_sum[WIDTH-1] != s1_ctl.a_msb);

`ifdef CSEL_ADDSUB_SAT_EN
  // Overflow direction follows the shared operand sign: negative operands clamp to min.
  always_comb begin
    res_sum = raw_sum;
    if (s1_sat && res_ovf) begin
      res_sum = s1_ctl.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res_sum = raw_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_take) begin
      out_valid <= s1_ctl.valid;
      if (s1_ctl.valid) begin
        sum   <= res_sum;
        c_out <= (s1_ctl.mode == MODE_SUB) ? ~chain[NB] : chain[NB];
        ovf   <= res_ovf;
        zero  <= (res_sum == '0);
      end
    end
  end

endmodule

// File: doc/pipelined_csel_addsub.md
PIPELINED_CSEL_ADDSUB -- requirements
Module: pipelined_csel_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of BLOCK, minimum 4.
REQ-002 Parameter BLOCK, default 4, carry-select block width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands valid this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 c_in  input  1  carry-in (add) or borrow-in (sub).
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 c_out  output  1  carry-out (add) or borrow-out (sub).
REQ-014 ovf  output  1  signed two's-complement overflow.
REQ-015 zero  output  1  sum == 0.

Function
REQ-016 Add: {c_out,sum} = a + b + c_in.
REQ-017 Sub: sum = a - b - c_in, computed as a + ~b + !c_in; c_out = NOT of the internal carry (1 = borrow).
REQ-018 ovf SHALL be set when operand signs (b inverted for sub) match and the sum sign differs.
REQ-019 Stage 1 SHALL register, per BLOCK slice, both candidate sums and carries (carry-in 0 and 1), plus the mode.
REQ-020 Stage 2 SHALL resolve the block carry chain by selection and register sum, c_out, ovf and zero.
REQ-021 Latency SHALL be exactly 2 cycles from accepted input to out_valid when not stalled; throughput 1 per cycle.
REQ-022 A transfer occurs on in_valid && in_ready, or out_valid && out_ready.
REQ-023 A stage SHALL advance when it is empty or the next stage advances; in_ready = stage-1 empty or stage 1 advancing.
REQ-024 While out_valid && !out_ready, sum/c_out/ovf/zero SHALL hold stable.
REQ-025 Simultaneous accept and drain with both stages full SHALL lose no data and insert no bubble.
REQ-026 Inputs SHALL be ignored when in_valid is 0; in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-027 On rst_n low: out_valid=0, both stage-valid flags 0, sum=0, c_out=0, ovf=0, zero=0, and in_ready=1 on the first cycle after release.
REQ-028 Reset mid-operation SHALL discard in-flight results; no result SHALL emerge afterwards.

Configuration
REQ-029 Macro CSEL_ADDSUB_SAT_EN: when defined, the port sat (input, 1) SHALL be present; with sat=1 and ovf set, sum SHALL clamp to signed max (0x7FFF at WIDTH=16) on positive overflow or signed min (0x8000) on negative overflow. ovf SHALL still report the overflow.
REQ-030 Without CSEL_ADDSUB_SAT_EN, the sat port SHALL be absent and the result SHALL wrap modulo 2^WIDTH.

Structure
REQ-031 Package csel_pkg SHALL hold the mode constants (MODE_ADD, MODE_SUB), the default WIDTH/BLOCK and the stage-record typedef.
REQ-032 Sub-module csel_block SHALL implement one BLOCK-bit slice with outputs sum0/sum1/cout0/cout1; it SHALL be instantiated WIDTH/BLOCK times.

Verification
REQ-033 Add: a=0x0003, b=0x0001, c_in=0, sub=0 -> sum=0x0004, c_out=0, ovf=0, zero=0, out_valid exactly 2 cycles after accept.
REQ-034 Sub with borrow: a=0x0000, b=0x0001, c_in=0, sub=1 -> sum=0xFFFF, c_out=1, ovf=0; a=0x0005, b=0x0005 -> sum=0x0000, zero=1, c_out=0.
REQ-035 Overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1 (with macro and sat=1 -> sum=0x7FFF, ovf=1).
REQ-036 Backpressure: stream 4 operands with out_ready=0 -> in_ready falls after 2 accepts, output holds; release -> all 4 results in order, none lost.
REQ-037 Reset mid-stream: assert rst_n low with both stages full -> out_valid=0 immediately; after release no stale result appears.
REQ-038 Random: 10k random a/b/c_in/sub at WIDTH=16, BLOCK=4 and WIDTH=32, BLOCK=8 with random out_ready -> all fields match the reference model.
